// File: rtl/au_updn_cnt.sv
// Registered up/down counter with parallel load, wrap or saturate limits and
// one-cycle overflow/underflow pulses; both count paths use prefix-AND lookahead.

module au_prefix_and #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] p
);

  // p[i] = &a[i:0]
  function automatic logic [WIDTH-1:0] prefix_ripple(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int i = 1; i < WIDTH; i++) r[i] = r[i] & r[i-1];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] prefix_kogge_stone(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] n;
    r = x;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      n = r;
      for (int i = d; i < WIDTH; i++) n[i] = r[i] & r[i-d];
      r = n;
    end
    return r;
  endfunction

  // Each level joins the upper half of every 2d block to the last bit of its lower half.
  function automatic logic [WIDTH-1:0] prefix_sklansky(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i & d) != 0) r[i] = r[i] & r[(i / (2 * d)) * (2 * d) + d - 1];
      end
    end
    return r;
  endfunction

  generate
    if (ARCH == 1) begin : g_kogge_stone
      assign p = prefix_kogge_stone(a);
    end else if (ARCH == 2) begin : g_sklansky
      assign p = prefix_sklansky(a);
    end else begin : g_ripple
      assign p = prefix_ripple(a);
    end
  endgenerate

endmodule

module au_updn_cnt #(
  parameter int               WIDTH   = 8,
  parameter int               ARCH    = 0,
  parameter int               SAT     = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             max,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_inv;
  logic [WIDTH-1:0] inc_and;
  logic [WIDTH-1:0] dec_and;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign cnt_inv = ~cnt;

  au_prefix_and #(.WIDTH(WIDTH), .ARCH(ARCH)) u_inc_and (.a(cnt),     .p(inc_and));
  au_prefix_and #(.WIDTH(WIDTH), .ARCH(ARCH)) u_dec_and (.a(cnt_inv), .p(dec_and));

  // Bit i flips when every lower bit is one (increment) or zero (decrement).
  assign cnt_inc = cnt ^ ((inc_and << 1) | ONE);
  assign cnt_dec = cnt ^ ((dec_and << 1) | ONE);

  // The full-width prefix terms are the carry-out and borrow-out.
  assign max  = inc_and[WIDTH-1];
  assign zero = dec_and[WIDTH-1];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_nxt = cnt;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (ld) begin
      cnt_nxt = ld_val;
    end else if (en && up) begin
      ovf_nxt = max;
      cnt_nxt = (max && SAT != 0) ? cnt : cnt_inc;
    end else if (en) begin
      unf_nxt = zero;
      cnt_nxt = (zero && SAT != 0) ? cnt : cnt_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      cnt <= RST_VAL;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

endmodule
